// File: rtl/valu_wb_ctrl.sv
// ---------------------------------------------------------------------------
// valu_wb_ctrl
//
// Issue / writeback controller sitting in front of a fixed-latency vector ALU.
// It tracks which vector and scalar registers have a write outstanding,
// stalls the issuing stage on RAW/WAW hazards, and carries a destination
// tag alongside the ALU pipeline so that the ALU result can be steered into
// the right register file exactly LAT cycles after issue.
//
// Parameters
//   LAT   ALU pipeline depth in cycles (1..15)
//   NREG  number of vector registers and number of scalar registers
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         issue handshake (in_ready is combinational)
//   in_op, in_vs1, in_vs2       opcode and vector source registers
//   in_dst, in_dst_scalar       destination index and register-file select
//   in_wb_en                    instruction writes a destination
//   alu_en, alu_op              issue strobe and opcode to the ALU
//   alu_vout, alu_rout          ALU vector (4x32) and scalar results
//   wb_valid, wb_dst_scalar,
//   wb_dst, wb_vdata, wb_rdata  register-file write port
//   busy                        at least one writing instruction in flight
// ---------------------------------------------------------------------------
module valu_wb_ctrl #(
    parameter int LAT  = 5,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   in_op,
    input  logic [4:0]   in_vs1,
    input  logic [4:0]   in_vs2,
    input  logic [4:0]   in_dst,
    input  logic         in_dst_scalar,
    input  logic         in_wb_en,
    output logic         alu_en,
    output logic [4:0]   alu_op,
    input  logic [127:0] alu_vout,
    input  logic [31:0]  alu_rout,
    output logic         wb_valid,
    output logic         wb_dst_scalar,
    output logic [4:0]   wb_dst,
    output logic [127:0] wb_vdata,
    output logic [31:0]  wb_rdata,
    output logic         busy
);

    // Destination tag travelling alongside the ALU pipeline.
    typedef struct packed {
        logic       valid;
        logic       dst_scalar;
        logic [4:0] dst;
    } tag_t;

    // One-hot select of a register index; indices at or above NREG select
    // nothing, so they can never stall nor mark a bit pending.
    function automatic logic [NREG-1:0] reg_mask(input logic [4:0] idx);
        logic [NREG-1:0] m;
        m = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(idx) == i) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    logic [NREG-1:0] vpend_q;
    logic [NREG-1:0] vpend_d;
    logic [NREG-1:0] spend_q;
    logic [NREG-1:0] spend_d;
    tag_t            tag_q [LAT];
    tag_t            tag_d [LAT];

    logic            src_hazard_s;
    logic            dst_hazard_s;
    logic            accept_s;
    logic            issue_wr_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;

    // Hazard detection against the pending bitmaps and issue handshake.
    always_comb begin
        src_hazard_s = (|(vpend_q & reg_mask(in_vs1))) |
                       (|(vpend_q & reg_mask(in_vs2)));
        if (in_wb_en) begin
            if (in_dst_scalar) begin
                dst_hazard_s = |(spend_q & reg_mask(in_dst));
            end else begin
                dst_hazard_s = |(vpend_q & reg_mask(in_dst));
            end
        end else begin
            dst_hazard_s = 1'b0;
        end
        // Reset gating keeps the issue side quiet while rst_n is low.
        in_ready   = rst_n & ~src_hazard_s & ~dst_hazard_s;
        accept_s   = in_valid & in_ready;
        issue_wr_s = accept_s & in_wb_en;
        alu_en     = accept_s;
        alu_op     = in_op;
    end

    // Writeback port driven straight from the final tag stage.
    always_comb begin
        wb_valid      = rst_n & tag_q[LAT-1].valid;
        wb_dst_scalar = tag_q[LAT-1].dst_scalar;
        wb_dst        = tag_q[LAT-1].dst;
        wb_vdata      = alu_vout;
        wb_rdata      = alu_rout;
    end

    // busy is the OR of every tag-stage valid bit.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

    // Tag shift register next state: a bubble is inserted whenever nothing
    // writing is accepted, so in-flight tags always advance one stage/cycle.
    always_comb begin
        for (int i = 0; i < LAT; i++) begin
            tag_d[i] = '0;
        end
        if (issue_wr_s) begin
            tag_d[0] = '{valid: 1'b1, dst_scalar: in_dst_scalar, dst: in_dst};
        end else begin
            tag_d[0] = '0;
        end
        for (int i = 1; i < LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Pending bitmap next state; the set term is OR-ed last so a set wins
    // over a clear of the same bit on the same edge.
    always_comb begin
        if (issue_wr_s) begin
            set_mask_s = reg_mask(in_dst);
        end else begin
            set_mask_s = '0;
        end
        if (wb_valid) begin
            clr_mask_s = reg_mask(wb_dst);
        end else begin
            clr_mask_s = '0;
        end
        vpend_d = vpend_q;
        spend_d = spend_q;
        if (wb_dst_scalar) begin
            spend_d = spend_d & ~clr_mask_s;
        end else begin
            vpend_d = vpend_d & ~clr_mask_s;
        end
        if (in_dst_scalar) begin
            spend_d = spend_d | set_mask_s;
        end else begin
            vpend_d = vpend_d | set_mask_s;
        end
    end

    // State registers with synchronous active-low reset; reset drops every
    // in-flight tag so late ALU results never produce a writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vpend_q <= '0;
            spend_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vpend_q <= vpend_d;
            spend_q <= spend_d;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule
